// File: rtl/fetch_unit.sv
// Fetch stage: holds the fetch PC, keeps one instruction-memory read in flight,
// and buffers the returned word with its PC for decode. Redirects kill stale fetches.
module fetch_unit #(
  parameter int                    DataWidth    = 32,
  parameter int                    AddressWidth = 10,
  parameter logic [AddressWidth-1:0] ResetPc    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    imem_req_o,
  output logic [AddressWidth-1:0] imem_addr_o,
  input  logic                    imem_gnt_i,
  input  logic                    imem_rvalid_i,
  input  logic [DataWidth-1:0]    imem_rdata_i,
  input  logic                    redirect_i,
  input  logic [AddressWidth-1:0] redirect_pc_i,
  output logic                    instr_valid_o,
  output logic [DataWidth-1:0]    instr_o,
  output logic [AddressWidth-1:0] instr_pc_o,
  output logic [AddressWidth-1:0] pc_plus4_o,
  input  logic                    instr_ready_i
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  localparam logic [AddressWidth-1:0] Four = AddressWidth'(4);

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [AddressWidth-1:0] infl_pc_q, infl_pc_d;
  logic                    kill_q, kill_d;
  logic                    valid_q, valid_d;
  logic [DataWidth-1:0]    instr_q, instr_d;
  logic [AddressWidth-1:0] ipc_q, ipc_d;
  logic [AddressWidth-1:0] pc4_q, pc4_d;
  logic [AddressWidth-1:0] redir_pc;

  assign redir_pc = redirect_pc_i & ~AddressWidth'(3);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    pc4_d      = pc4_q;
    case (state_q)
      S_REQ: begin
        if (imem_gnt_i) begin
          // A grant alongside a redirect still accepts the old-path read, so mark it dead.
          infl_pc_d  = fetch_pc_q;
          fetch_pc_d = redirect_i ? redir_pc : fetch_pc_q + Four;
          kill_d     = redirect_i;
          state_d    = S_WAIT;
        end else if (redirect_i) begin
          fetch_pc_d = redir_pc;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (redirect_i) fetch_pc_d = redir_pc;
          if (!redirect_i && !kill_q) begin
            instr_d = imem_rdata_i;
            ipc_d   = infl_pc_q;
            pc4_d   = infl_pc_q + Four;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_REQ;
          end
        end else if (redirect_i) begin
          kill_d     = 1'b1;
          fetch_pc_d = redir_pc;
        end
      end
      S_HOLD: begin
        // Ready with a redirect is a single consumption: the buffered instruction caused it.
        if (redirect_i) fetch_pc_d = redir_pc;
        if (redirect_i || instr_ready_i) begin
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      fetch_pc_q <= ResetPc;
      infl_pc_q  <= '0;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= '0;
      pc4_q      <= Four;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      pc4_q      <= pc4_d;
    end
  end

  // Request is a flop decode; reset only masks it so nothing leaks out while held in reset.
  assign imem_req_o    = (state_q == S_REQ) && !rst_i;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign pc_plus4_o    = pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives the memory and decode handshakes and checks
// delivered instructions against a queue of expected {data, pc} pairs.
module tb_fetch_unit;

  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, gnt, rvalid, redirect, ready;
  logic [DW-1:0] rdata;
  logic [AW-1:0] redirect_pc;
  logic          req, valid;
  logic [AW-1:0] addr, ipc, pc4;
  logic [DW-1:0] instr;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DataWidth(DW), .AddressWidth(AW), .ResetPc('0)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc),
    .pc_plus4_o(pc4), .instr_ready_i(ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered in a REQ cycle; grant after gd idle cycles, rvalid rd cycles after grant.
  task automatic do_fetch(input int gd, input int rd, input logic [DW-1:0] d, input logic [AW-1:0] a);
    exp_t e;
    for (int i = 0; i < gd; i++) begin
      chk("req_hold", 32'(req), 1);
      chk("addr_hold", 32'(addr), 32'(a));
      tick();
    end
    chk("req", 32'(req), 1);
    chk("addr", 32'(addr), 32'(a));
    gnt = 1'b1; tick(); gnt = 1'b0;
    for (int i = 1; i < rd; i++) begin
      chk("wait_noreq", 32'(req), 0);
      chk("wait_novalid", 32'(valid), 0);
      tick();
    end
    rvalid = 1'b1; rdata = d; tick(); rvalid = 1'b0; rdata = '0;
    e.d = d; e.pc = a;
    q.push_back(e);
  endtask

  task automatic consume(input int stall);
    exp_t e;
    logic [AW-1:0] p4;
    if (q.size() == 0) begin
      chk("queue_nonempty", 0, 1);
      return;
    end
    e  = q.pop_front();
    p4 = e.pc + AW'(4);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 32'(valid), 1);
      chk("stall_instr", instr, e.d);
      chk("stall_pc", 32'(ipc), 32'(e.pc));
      tick();
    end
    chk("valid", 32'(valid), 1);
    chk("instr", instr, e.d);
    chk("instr_pc", 32'(ipc), 32'(e.pc));
    chk("pc_plus4", 32'(pc4), 32'(p4));
    ready = 1'b1; tick(); ready = 1'b0;
    chk("consumed_once", 32'(valid), 0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0; ready = 1'b0;
    rdata = '0; redirect_pc = '0;
    tick(); tick();
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", 32'(ipc), 0);
    rst = 1'b0; #1;

    // sequential fetch, best case
    do_fetch(0, 1, 32'hA000_0000, 10'h000); consume(0);
    do_fetch(0, 1, 32'hA000_0004, 10'h004); consume(0);
    do_fetch(0, 1, 32'hA000_0008, 10'h008); consume(0);

    // memory and decode backpressure
    do_fetch(3, 2, 32'hB000_000C, 10'h00C); consume(4);

    // redirect while waiting on rvalid
    chk("w_addr", 32'(addr), 32'h010);
    gnt = 1'b1; tick(); gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 10'h123; tick(); redirect = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_0010; tick(); rvalid = 1'b0;
    chk("w_killed", 32'(valid), 0);
    do_fetch(0, 1, 32'hC000_0120, 10'h120); consume(0);

    // redirect with grant in the same cycle
    chk("g_addr", 32'(addr), 32'h124);
    gnt = 1'b1; redirect = 1'b1; redirect_pc = 10'h200; tick();
    gnt = 1'b0; redirect = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_0124; tick(); rvalid = 1'b0;
    chk("g_killed", 32'(valid), 0);
    do_fetch(0, 1, 32'hC000_0200, 10'h200); consume(0);

    // redirect with rvalid in the same cycle
    gnt = 1'b1; tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_0204; redirect = 1'b1; redirect_pc = 10'h300; tick();
    rvalid = 1'b0; redirect = 1'b0;
    chk("r_dropped", 32'(valid), 0);
    chk("r_req", 32'(req), 1);
    chk("r_addr", 32'(addr), 32'h300);
    tick();
    chk("r_still_dropped", 32'(valid), 0);
    do_fetch(0, 1, 32'hC000_0300, 10'h300); consume(0);

    // redirect with valid&ready in HOLD; low address bits ignored
    do_fetch(0, 1, 32'hC000_0304, 10'h304);
    e = q.pop_front();
    chk("h_valid", 32'(valid), 1);
    chk("h_instr", instr, e.d);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 10'h3FF; tick();
    ready = 1'b0; redirect = 1'b0;
    chk("h_no_dup", 32'(valid), 0);
    chk("h_addr", 32'(addr), 32'h3FC);

    // wrap, then reset mid-fetch with a late rvalid
    do_fetch(0, 1, 32'hE000_03FC, 10'h3FC); consume(0);
    chk("wrap_addr", 32'(addr), 32'h000);
    gnt = 1'b1; tick(); gnt = 1'b0;
    rst = 1'b1; tick();
    chk("mid_rst_req", 32'(req), 0);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0000; #1;
    chk("post_rst_req", 32'(req), 1);
    chk("post_rst_addr", 32'(addr), 32'h000);
    chk("post_rst_pc", 32'(ipc), 0);
    tick(); rvalid = 1'b0; rdata = '0;
    chk("late_rvalid_ignored", 32'(valid), 0);
    chk("late_req", 32'(req), 1);
    do_fetch(1, 1, 32'hF000_0000, 10'h000); consume(0);
    chk("queue_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
